control_unit: RTL and testbench



---
 rtl/control_pkg.sv | 74 +++++++
 rtl/control_unit_instr_class_decoder.sv | 38 +++
 rtl/control_unit.sv | 239 +++++++++++++++++++++++
 tb/tb_control_unit.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// control_pkg: ISA header macros plus the shared state enum, instruction
// classes and datapath select encodings for the RV32I control unit.
// Optional debug halt support is enabled by defining CONTROL_UNIT__DEBUG_EN.

`ifndef ISA__DEFS_SVH
`define ISA__DEFS_SVH
`define ISA__OPCODE_WIDTH 7
`define ISA__FUNCT3_WIDTH 3
`define ISA__OPC_LUI      7'b0110111
`define ISA__OPC_AUIPC    7'b0010111
`define ISA__OPC_JAL      7'b1101111
`define ISA__OPC_JALR     7'b1100111
`define ISA__OPC_BRANCH   7'b1100011
`define ISA__OPC_LOAD     7'b0000011
`define ISA__OPC_STORE    7'b0100011
`define ISA__OPC_OP_IMM   7'b0010011
`define ISA__OPC_OP       7'b0110011
`define ISA__OPC_MISC_MEM 7'b0001111
`define ISA__OPC_SYSTEM   7'b1110011
`endif

package control_pkg;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM_RD,
    ST_LOAD_WB,
    ST_MEM_WR,
    ST_PC_INC,
    ST_TRAP
`ifdef CONTROL_UNIT__DEBUG_EN
    , ST_HALTED
`endif
  } state_t;

  typedef enum logic [3:0] {
    IC_OP,
    IC_OP_IMM,
    IC_LUI,
    IC_AUIPC,
    IC_JAL,
    IC_JALR,
    IC_BRANCH,
    IC_LOAD,
    IC_STORE,
    IC_FENCE,
    IC_SYSTEM,
    IC_ILLEGAL
  } instr_class_t;

  // Register-file write-back source
  localparam logic [1:0] RD_SEL_ALU = 2'd0;
  localparam logic [1:0] RD_SEL_MDR = 2'd1;
  localparam logic [1:0] RD_SEL_PC4 = 2'd2;
  localparam logic [1:0] RD_SEL_CSR = 2'd3;

  // ALU operand A source
  localparam logic [1:0] INSEL1_RS1  = 2'd0;
  localparam logic [1:0] INSEL1_PC   = 2'd1;
  localparam logic [1:0] INSEL1_ZERO = 2'd2;

  // ALU operand B source
  localparam logic [1:0] INSEL2_RS2  = 2'd0;
  localparam logic [1:0] INSEL2_IMM  = 2'd1;
  localparam logic [1:0] INSEL2_FOUR = 2'd2;

  // Memory address source
  localparam logic ADDR_SEL_PC  = 1'b0;
  localparam logic ADDR_SEL_ALU = 1'b1;

endpackage

// File: rtl/control_unit_instr_class_decoder.sv
// instr_class_decoder: purely combinational map from opcode/funct3 of the
// instruction register to an instruction class and a legality flag.

module instr_class_decoder
  import control_pkg::*;
(
  input  logic [`ISA__OPCODE_WIDTH-1:0] opcode,
  input  logic [`ISA__FUNCT3_WIDTH-1:0] f3,
  output instr_class_t                  instr_class,
  output logic                          legal
);

  // Classify the opcode; SYSTEM with funct3 000 or 100 is not supported
  always_comb begin
    instr_class = IC_ILLEGAL;
    case (opcode)
      `ISA__OPC_OP:       instr_class = IC_OP;
      `ISA__OPC_OP_IMM:   instr_class = IC_OP_IMM;
      `ISA__OPC_LUI:      instr_class = IC_LUI;
      `ISA__OPC_AUIPC:    instr_class = IC_AUIPC;
      `ISA__OPC_JAL:      instr_class = IC_JAL;
      `ISA__OPC_JALR:     instr_class = IC_JALR;
      `ISA__OPC_BRANCH:   instr_class = IC_BRANCH;
      `ISA__OPC_LOAD:     instr_class = IC_LOAD;
      `ISA__OPC_STORE:    instr_class = IC_STORE;
      `ISA__OPC_MISC_MEM: instr_class = IC_FENCE;
      `ISA__OPC_SYSTEM: begin
        if (f3 != 3'b000 && f3 != 3'b100) begin
          instr_class = IC_SYSTEM;
        end
      end
      default:            instr_class = IC_ILLEGAL;
    endcase
  end

  assign legal = (instr_class != IC_ILLEGAL);

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle RV32I control FSM. Sequences fetch, decode,
// execute, memory access and PC update one instruction at a time, driving
// every strobe and select of the datapath from the current state.
// Define CONTROL_UNIT__DEBUG_EN to add halt_req/resume_req/halted and the
// HALTED state; halts are only taken at instruction boundaries.

module control_unit
  import control_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [`ISA__OPCODE_WIDTH-1:0] opcode,
  input  logic [`ISA__FUNCT3_WIDTH-1:0] f3,
  input  logic                          branch_taken,
  input  logic                          mem_complete_read,
  input  logic                          mem_complete_write,
  output logic                          store,
  output logic                          write_pc,
  output logic                          write_ir,
  output logic                          write_rd,
  output logic                          write_csr,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic                          addr_sel,
  output logic [1:0]                    rd_sel,
  output logic [1:0]                    alu_insel1,
  output logic [1:0]                    alu_insel2,
  output logic                          retire,
  output logic                          illegal
`ifdef CONTROL_UNIT__DEBUG_EN
  ,
  input  logic                          halt_req,
  input  logic                          resume_req,
  output logic                          halted
`endif
);

  state_t       state;
  state_t       state_nxt;
  instr_class_t iclass;
  logic         iclass_legal;

  instr_class_decoder u_decoder (
    .opcode      (opcode),
    .f3          (f3),
    .instr_class (iclass),
    .legal       (iclass_legal)
  );

  // State register; reset returns to INIT from any state, including TRAP
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Sticky illegal flag, set on the transition into TRAP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal <= 1'b0;
    end else if (state_nxt == ST_TRAP) begin
      illegal <= 1'b1;
    end
  end

  // Next-state and state-decoded outputs
  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    store      = 1'b0;
    write_pc   = 1'b0;
    write_ir   = 1'b0;
    write_rd   = 1'b0;
    write_csr  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    addr_sel   = ADDR_SEL_PC;
    rd_sel     = RD_SEL_ALU;
    alu_insel1 = INSEL1_RS1;
    alu_insel2 = INSEL2_RS2;
    retire     = 1'b0;
`ifdef CONTROL_UNIT__DEBUG_EN
    halted     = 1'b0;
`endif

    case (state)
      ST_INIT: state_nxt = ST_FETCH;

      ST_FETCH: begin
        mem_read = 1'b1;
        addr_sel = ADDR_SEL_PC;
        if (mem_complete_read) begin
          write_ir  = 1'b1;
          state_nxt = ST_DECODE;
        end
      end

      ST_DECODE: state_nxt = iclass_legal ? ST_EXEC : ST_TRAP;

      ST_EXEC: begin
        case (iclass)
          IC_OP: begin
            alu_insel1 = INSEL1_RS1;
            alu_insel2 = INSEL2_RS2;
            write_rd   = 1'b1;
            rd_sel     = RD_SEL_ALU;
            state_nxt  = ST_PC_INC;
          end
          IC_OP_IMM: begin
            alu_insel1 = INSEL1_RS1;
            alu_insel2 = INSEL2_IMM;
            write_rd   = 1'b1;
            rd_sel     = RD_SEL_ALU;
            state_nxt  = ST_PC_INC;
          end
          IC_LUI: begin
            alu_insel1 = INSEL1_ZERO;
            alu_insel2 = INSEL2_IMM;
            write_rd   = 1'b1;
            rd_sel     = RD_SEL_ALU;
            state_nxt  = ST_PC_INC;
          end
          IC_AUIPC: begin
            alu_insel1 = INSEL1_PC;
            alu_insel2 = INSEL2_IMM;
            write_rd   = 1'b1;
            rd_sel     = RD_SEL_ALU;
            state_nxt  = ST_PC_INC;
          end
          IC_JAL: begin
            write_rd   = 1'b1;
            rd_sel     = RD_SEL_PC4;
            alu_insel1 = INSEL1_PC;
            alu_insel2 = INSEL2_IMM;
            write_pc   = 1'b1;
            retire     = 1'b1;
            state_nxt  = ST_FETCH;
          end
          IC_JALR: begin
            write_rd   = 1'b1;
            rd_sel     = RD_SEL_PC4;
            alu_insel1 = INSEL1_RS1;
            alu_insel2 = INSEL2_IMM;
            write_pc   = 1'b1;
            retire     = 1'b1;
            state_nxt  = ST_FETCH;
          end
          IC_BRANCH: begin
            if (branch_taken) begin
              alu_insel1 = INSEL1_PC;
              alu_insel2 = INSEL2_IMM;
              write_pc   = 1'b1;
              retire     = 1'b1;
              state_nxt  = ST_FETCH;
            end else begin
              state_nxt  = ST_PC_INC;
            end
          end
          IC_LOAD:  state_nxt = ST_MEM_RD;
          IC_STORE: state_nxt = ST_MEM_WR;
          IC_FENCE: state_nxt = ST_PC_INC;
          IC_SYSTEM: begin
            write_rd  = 1'b1;
            rd_sel    = RD_SEL_CSR;
            write_csr = 1'b1;
            state_nxt = ST_PC_INC;
          end
          default:  state_nxt = ST_TRAP;
        endcase
      end

      ST_MEM_RD: begin
        alu_insel1 = INSEL1_RS1;
        alu_insel2 = INSEL2_IMM;
        addr_sel   = ADDR_SEL_ALU;
        mem_read   = 1'b1;
        if (mem_complete_read) begin
          store     = 1'b1;
          state_nxt = ST_LOAD_WB;
        end
      end

      ST_LOAD_WB: begin
        write_rd   = 1'b1;
        rd_sel     = RD_SEL_MDR;
        alu_insel1 = INSEL1_PC;
        alu_insel2 = INSEL2_FOUR;
        write_pc   = 1'b1;
        retire     = 1'b1;
        state_nxt  = ST_FETCH;
      end

      ST_MEM_WR: begin
        alu_insel1 = INSEL1_RS1;
        alu_insel2 = INSEL2_IMM;
        addr_sel   = ADDR_SEL_ALU;
        mem_write  = 1'b1;
        if (mem_complete_write) begin
          state_nxt = ST_PC_INC;
        end
      end

      ST_PC_INC: begin
        alu_insel1 = INSEL1_PC;
        alu_insel2 = INSEL2_FOUR;
        write_pc   = 1'b1;
        retire     = 1'b1;
        state_nxt  = ST_FETCH;
      end

      ST_TRAP: state_nxt = ST_TRAP;

`ifdef CONTROL_UNIT__DEBUG_EN
      ST_HALTED: begin
        halted = 1'b1;
        if (resume_req) begin
          state_nxt = ST_FETCH;
        end
      end
`endif

      default: state_nxt = ST_INIT;
    endcase

`ifdef CONTROL_UNIT__DEBUG_EN
    // Instruction boundary: any entry into FETCH (from INIT or a retiring
    // state) is diverted to HALTED while a halt is requested. Holding in
    // FETCH and resuming from HALTED are not boundaries.
    if (halt_req && state_nxt == ST_FETCH &&
        state != ST_FETCH && state != ST_HALTED) begin
      state_nxt = ST_HALTED;
    end
`endif
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized self-checking bench for control_unit with a
// memory/instruction-register responder, a scoreboard of per-instruction
// expectations and an independent monitor.

module tb_control_unit;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] f3 = '0;
  logic       branch_taken = 1'b0;
  logic       mem_complete_read = 1'b0;
  logic       mem_complete_write = 1'b0;
  logic       store, write_pc, write_ir, write_rd, write_csr;
  logic       mem_read, mem_write, addr_sel, retire, illegal;
  logic [1:0] rd_sel, alu_insel1, alu_insel2;
`ifdef CONTROL_UNIT__DEBUG_EN
  logic       halt_req = 1'b0;
  logic       resume_req = 1'b0;
  logic       halted;
`endif

  control_unit dut (
    .clk                (clk),
    .rst                (rst),
    .opcode             (opcode),
    .f3                 (f3),
    .branch_taken       (branch_taken),
    .mem_complete_read  (mem_complete_read),
    .mem_complete_write (mem_complete_write),
    .store              (store),
    .write_pc           (write_pc),
    .write_ir           (write_ir),
    .write_rd           (write_rd),
    .write_csr          (write_csr),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .addr_sel           (addr_sel),
    .rd_sel             (rd_sel),
    .alu_insel1         (alu_insel1),
    .alu_insel2         (alu_insel2),
    .retire             (retire),
    .illegal            (illegal)
`ifdef CONTROL_UNIT__DEBUG_EN
    ,
    .halt_req           (halt_req),
    .resume_req         (resume_req),
    .halted             (halted)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] out_vec;
  assign out_vec = {store, write_pc, write_ir, write_rd, write_csr, mem_read,
                    mem_write, addr_sel, rd_sel, alu_insel1, alu_insel2,
                    retire, illegal};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  typedef struct {
    logic [6:0] opcode;
    logic [2:0] f3;
    logic       taken;
    int         fetch_wait;
    int         data_wait;
  } instr_t;

  typedef struct {
    bit trap;
    int cycles;
    int fetch_cycles;
    int n_rd;
    int rd_sel;
    int rd_in1;
    int rd_in2;
    int n_csr;
    int pc_in1;
    int pc_in2;
    int data_rd_cycles;
    int n_store;
    int wr_cycles;
  } exp_t;

  instr_t instr_q[$];
  exp_t   exp_q[$];

  function automatic instr_t mk(input logic [6:0] op, input logic [2:0] fn3,
                                input logic tk, input int fw, input int dw);
    instr_t i;
    i.opcode = op; i.f3 = fn3; i.taken = tk; i.fetch_wait = fw; i.data_wait = dw;
    return i;
  endfunction

  // Reference model: what one instruction should look like end to end,
  // counted in cycles from the first fetch request cycle.
  function automatic exp_t model(input instr_t i);
    exp_t e;
    int   through_decode;
    e = '{default: 0};
    e.fetch_cycles = i.fetch_wait + 1;
    through_decode = e.fetch_cycles + 1;
    e.pc_in1 = 1;  // PC + 4 unless a jump/branch target overrides
    e.pc_in2 = 2;
    e.cycles = through_decode + 2;
    case (i.opcode)
      OPC_OP:     begin e.n_rd = 1; e.rd_sel = 0; e.rd_in1 = 0; e.rd_in2 = 0; end
      OPC_OP_IMM: begin e.n_rd = 1; e.rd_sel = 0; e.rd_in1 = 0; e.rd_in2 = 1; end
      OPC_LUI:    begin e.n_rd = 1; e.rd_sel = 0; e.rd_in1 = 2; e.rd_in2 = 1; end
      OPC_AUIPC:  begin e.n_rd = 1; e.rd_sel = 0; e.rd_in1 = 1; e.rd_in2 = 1; end
      OPC_JAL: begin
        e.cycles = through_decode + 1;
        e.n_rd = 1; e.rd_sel = 2; e.rd_in1 = 1; e.rd_in2 = 1;
        e.pc_in1 = 1; e.pc_in2 = 1;
      end
      OPC_JALR: begin
        e.cycles = through_decode + 1;
        e.n_rd = 1; e.rd_sel = 2; e.rd_in1 = 0; e.rd_in2 = 1;
        e.pc_in1 = 0; e.pc_in2 = 1;
      end
      OPC_BRANCH: begin
        if (i.taken) begin
          e.cycles = through_decode + 1;
          e.pc_in1 = 1; e.pc_in2 = 1;
        end
      end
      OPC_LOAD: begin
        e.data_rd_cycles = i.data_wait + 1;
        e.cycles = through_decode + 1 + e.data_rd_cycles + 1;
        e.n_store = 1;
        e.n_rd = 1; e.rd_sel = 1; e.rd_in1 = 1; e.rd_in2 = 2;
      end
      OPC_STORE: begin
        e.wr_cycles = i.data_wait + 1;
        e.cycles = through_decode + 1 + e.wr_cycles + 1;
      end
      OPC_MISC_MEM: ;
      OPC_SYSTEM: begin
        if (i.f3 == 3'b000 || i.f3 == 3'b100) begin
          e.trap = 1'b1;
        end else begin
          e.n_rd = 1; e.rd_sel = 3; e.rd_in1 = 0; e.rd_in2 = 0; e.n_csr = 1;
        end
      end
      default: e.trap = 1'b1;
    endcase
    if (e.trap) begin
      e = '{default: 0};
      e.trap = 1'b1;
      e.fetch_cycles = i.fetch_wait + 1;
      e.cycles = e.fetch_cycles + 2;  // FETCH, DECODE, first TRAP cycle
    end
    return e;
  endfunction

  task automatic issue(input instr_t i);
    instr_q.push_back(i);
    exp_q.push_back(model(i));
  endtask

  // Memory and instruction-register responder: completes requests after the
  // programmed wait, loads the IR fields on fetch completion, and throws in
  // stray completion pulses whenever nothing is requested.
  initial begin
    instr_t cur;
    int     req_cnt;
    cur = mk(OPC_OP, 3'd0, 1'b0, 0, 0);
    req_cnt = 0;
    forever begin
      @(negedge clk);
      mem_complete_read  = 1'b0;
      mem_complete_write = 1'b0;
      if (rst) begin
        req_cnt = 0;
      end else if (mem_read && !addr_sel) begin
        if (instr_q.size() > 0 && req_cnt >= instr_q[0].fetch_wait) begin
          cur = instr_q.pop_front();
          mem_complete_read = 1'b1;
          opcode = cur.opcode;
          f3 = cur.f3;
          branch_taken = cur.taken;
          req_cnt = 0;
        end else begin
          req_cnt++;
        end
      end else if (mem_read) begin
        if (req_cnt >= cur.data_wait) begin
          mem_complete_read = 1'b1;
          req_cnt = 0;
        end else begin
          req_cnt++;
        end
      end else if (mem_write) begin
        if (req_cnt >= cur.data_wait) begin
          mem_complete_write = 1'b1;
          req_cnt = 0;
        end else begin
          req_cnt++;
        end
      end else begin
        req_cnt = 0;
        mem_complete_read  = ($urandom_range(0, 3) == 0);
        mem_complete_write = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Monitor: accumulates what the DUT did per instruction and compares it
  // with the scoreboard on retire or on entry into the trap.
  initial begin
    int   cyc, fcnt, nir, nrd, rsel, rin1, rin2, ncsr, drd, nst, wrc, nret;
    bit   init_pending, trap_seen;
    exp_t e;
    cyc = 0; fcnt = 0; nir = 0; nrd = 0; rsel = 0; rin1 = 0; rin2 = 0;
    ncsr = 0; drd = 0; nst = 0; wrc = 0; nret = 0;
    init_pending = 1'b0; trap_seen = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        cyc = 0; fcnt = 0; nir = 0; nrd = 0; ncsr = 0; drd = 0; nst = 0; wrc = 0;
        init_pending = 1'b1;
        trap_seen = 1'b0;
        continue;
      end
      if (init_pending) begin
        init_pending = 1'b0;
        check("init_outputs_zero", int'(out_vec), 0);
        continue;
      end
`ifdef CONTROL_UNIT__DEBUG_EN
      if (halted) begin
        check("halted_no_strobes", int'(out_vec), 0);
        continue;
      end
`endif
      if (illegal) begin
        if (!trap_seen) begin
          trap_seen = 1'b1;
          cyc++;
          check("trap_scoreboard_nonempty", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("trap_expected_by_model", int'(e.trap), 1);
            check("trap_cycles", cyc, e.cycles);
            check("trap_fetch_cycles", fcnt, e.fetch_cycles);
            check("trap_write_rd_count", nrd, 0);
          end
        end
        check("trap_only_illegal", int'(out_vec), 16'h0001);
        continue;
      end

      cyc++;
      if (mem_read && !addr_sel) fcnt++;
      if (mem_read && addr_sel)  drd++;
      if (write_ir)  nir++;
      if (store)     nst++;
      if (write_csr) ncsr++;
      if (mem_write) begin
        wrc++;
        check("store_addr_is_alu", int'(addr_sel), 1);
      end
      if (write_rd) begin
        nrd++;
        rsel = rd_sel; rin1 = alu_insel1; rin2 = alu_insel2;
      end
      check("write_pc_with_retire", int'(write_pc), int'(retire));
      check("write_pc_not_in_mem", int'(write_pc && (mem_read || mem_write || write_ir)), 0);

      if (retire) begin
        check($sformatf("ins%0d scoreboard_nonempty", nret), int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check($sformatf("ins%0d model_not_trap", nret), int'(e.trap), 0);
          check($sformatf("ins%0d cycles", nret), cyc, e.cycles);
          check($sformatf("ins%0d fetch_cycles", nret), fcnt, e.fetch_cycles);
          check($sformatf("ins%0d write_ir_count", nret), nir, 1);
          check($sformatf("ins%0d write_rd_count", nret), nrd, e.n_rd);
          if (e.n_rd > 0 && nrd > 0) begin
            check($sformatf("ins%0d rd_sel", nret), rsel, e.rd_sel);
            check($sformatf("ins%0d rd_insel1", nret), rin1, e.rd_in1);
            check($sformatf("ins%0d rd_insel2", nret), rin2, e.rd_in2);
          end
          check($sformatf("ins%0d write_csr_count", nret), ncsr, e.n_csr);
          check($sformatf("ins%0d pc_insel1", nret), int'(alu_insel1), e.pc_in1);
          check($sformatf("ins%0d pc_insel2", nret), int'(alu_insel2), e.pc_in2);
          check($sformatf("ins%0d data_read_cycles", nret), drd, e.data_rd_cycles);
          check($sformatf("ins%0d store_count", nret), nst, e.n_store);
          check($sformatf("ins%0d write_cycles", nret), wrc, e.wr_cycles);
        end
        nret++;
        cyc = 0; fcnt = 0; nir = 0; nrd = 0; ncsr = 0; drd = 0; nst = 0; wrc = 0;
      end
    end
  end

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_reset_outputs_zero"}, int'(out_vec), 0);
    check({tag, "_reset_illegal_clear"}, int'(illegal), 0);
    instr_q.delete();
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  function automatic logic [6:0] pick_op(input int k);
    case (k)
      0:  return OPC_OP;
      1:  return OPC_OP_IMM;
      2:  return OPC_LUI;
      3:  return OPC_AUIPC;
      4:  return OPC_JAL;
      5:  return OPC_JALR;
      6:  return OPC_BRANCH;
      7:  return OPC_LOAD;
      8:  return OPC_STORE;
      9:  return OPC_MISC_MEM;
      default: return OPC_SYSTEM;
    endcase
  endfunction

  initial begin
    instr_t     ri;
    int         n;
    logic [2:0] rf3;

    #1;
    do_reset("por");

    // Directed: 2-cycle first fetch, ADDI, LW with 3-cycle read, SW 0-wait, BEQ
    issue(mk(OPC_OP_IMM, 3'd0, 1'b0, 1, 0));
    issue(mk(OPC_OP_IMM, 3'd0, 1'b0, 0, 0));
    issue(mk(OPC_LOAD,   3'd2, 1'b0, 0, 2));
    issue(mk(OPC_STORE,  3'd2, 1'b0, 0, 0));
    issue(mk(OPC_BRANCH, 3'd0, 1'b1, 0, 0));
    issue(mk(OPC_BRANCH, 3'd0, 1'b0, 0, 0));
    issue(mk(OPC_SYSTEM, 3'd1, 1'b0, 0, 0));
    issue(mk(OPC_MISC_MEM, 3'd0, 1'b0, 0, 0));
    wait_drain("directed", 200);

    // Random legal instruction stream with random memory latency
    for (int k = 0; k < 150; k++) begin
      ri.opcode = pick_op($urandom_range(0, 10));
      rf3 = 3'($urandom_range(0, 7));
      if (ri.opcode == OPC_SYSTEM && (rf3 == 3'b000 || rf3 == 3'b100)) rf3 = 3'b001;
      ri.f3 = rf3;
      ri.taken = 1'($urandom_range(0, 1));
      ri.fetch_wait = $urandom_range(0, 3);
      ri.data_wait = $urandom_range(0, 3);
      issue(ri);
    end
    wait_drain("random", 5000);

    // Unknown opcode traps; illegal holds until reset
    issue(mk(7'b1111111, 3'd0, 1'b0, 0, 0));
    wait_drain("trap_7f", 100);
    repeat (3) @(negedge clk);
    #2;
    check("trap_illegal_held", int'(illegal), 1);
    do_reset("trap_7f");

    // SYSTEM with funct3 100 also traps
    issue(mk(OPC_SYSTEM, 3'b100, 1'b0, 1, 0));
    wait_drain("trap_sys100", 100);
    repeat (2) @(negedge clk);
    do_reset("trap_sys100");

    // Asynchronous reset in the middle of a slow fetch
    issue(mk(OPC_OP_IMM, 3'd0, 1'b0, 6, 0));
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!mem_read && n < 20);
    @(negedge clk);
    #3;
    check("midfetch_mem_read_before_reset", int'(mem_read), 1);
    do_reset("midfetch");
    issue(mk(OPC_OP, 3'd0, 1'b0, 0, 0));
    wait_drain("after_midfetch", 100);

`ifdef CONTROL_UNIT__DEBUG_EN
    // Halt requested during a load: the load retires, then HALTED
    issue(mk(OPC_LOAD, 3'd2, 1'b0, 0, 3));
    issue(mk(OPC_OP_IMM, 3'd0, 1'b0, 0, 0));
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(mem_read && addr_sel) && n < 50);
    check("dbg_reached_mem_rd", int'(mem_read && addr_sel), 1);
    halt_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!retire && n < 50);
    check("dbg_load_retired", int'(retire), 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("dbg_halted", int'(halted), 1);
      check("dbg_no_fetch_while_halted", int'(mem_read), 0);
    end
    halt_req = 1'b0;
    resume_req = 1'b1;
    @(negedge clk);
    #1;
    resume_req = 1'b0;
    check("dbg_resume_halted_low", int'(halted), 0);
    check("dbg_resume_fetch", int'(mem_read && !addr_sel), 1);
    wait_drain("dbg", 100);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
